// File: rtl/ex_redirect_ctl.sv
// EX-stage redirect controller: captures branch/exception targets, flushes, then hands the target to fetch.
// Optional REDIRECT_STATS_EN adds per-kind completed-redirect counters.
module ex_redirect_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_do_jump,
  input  logic [63:0] br_jump_pc,
  input  logic        exc_req,
  input  logic [63:0] exc_vector,
  input  logic        redir_ready,
  output logic        flush_out,
  output logic        redir_valid,
  output logic [63:0] redir_pc,
  output logic        ex_hold,
  output logic        exc_ack
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] br_redir_cnt,
  output logic [31:0] exc_redir_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, SEND} state_t;

  state_t      r_state;
  logic        r_flush;
  logic        r_valid;
  logic [63:0] r_pc;
  logic        r_hold;
  logic        r_ack;
  logic        r_is_exc;

  // A transfer completes whenever SEND meets ready, even if an exception is arriving in the same cycle.
  wire w_xfer = (r_state == SEND) && redir_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_flush  <= 1'b0;
      r_valid  <= 1'b0;
      r_pc     <= 64'h0;
      r_hold   <= 1'b0;
      r_ack    <= 1'b0;
      r_is_exc <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (exc_req) begin
            r_state  <= FLUSH;
            r_pc     <= exc_vector;
            r_ack    <= 1'b1;
            r_is_exc <= 1'b1;
            r_flush  <= 1'b1;
            r_hold   <= 1'b1;
          end else if (br_do_jump) begin
            r_state  <= FLUSH;
            r_pc     <= br_jump_pc;
            r_is_exc <= 1'b0;
            r_flush  <= 1'b1;
            r_hold   <= 1'b1;
          end
        end
        FLUSH: begin
          if (exc_req) begin
            r_pc     <= exc_vector;
            r_ack    <= 1'b1;
            r_is_exc <= 1'b1;
          end else begin
            r_state <= SEND;
            r_flush <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          // Exception either preempts (not ready) or chains after the transfer (ready); both re-flush.
          if (exc_req) begin
            r_state  <= FLUSH;
            r_pc     <= exc_vector;
            r_ack    <= 1'b1;
            r_is_exc <= 1'b1;
            r_flush  <= 1'b1;
            r_valid  <= 1'b0;
          end else if (redir_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_hold  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
          r_valid <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign flush_out   = r_flush;
  assign redir_valid = r_valid;
  assign redir_pc    = r_pc;
  assign ex_hold     = r_hold;
  assign exc_ack     = r_ack;

`ifdef REDIRECT_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_exc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt  <= 32'h0;
      r_exc_cnt <= 32'h0;
    end else if (w_xfer) begin
      if (r_is_exc) r_exc_cnt <= r_exc_cnt + 32'd1;
      else          r_br_cnt  <= r_br_cnt + 32'd1;
    end
  end

  assign br_redir_cnt  = r_br_cnt;
  assign exc_redir_cnt = r_exc_cnt;
`endif

endmodule

// File: tb/tb_ex_redirect_ctl.sv
// Randomized scoreboard bench for ex_redirect_ctl: expected redirects queued at issue, checked at handshake.
module tb_ex_redirect_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_do_jump = 1'b0;
  logic [63:0] br_jump_pc = 64'h0;
  logic        exc_req = 1'b0;
  logic [63:0] exc_vector = 64'h0;
  logic        redir_ready = 1'b0;
  logic        flush_out, redir_valid, ex_hold, exc_ack;
  logic [63:0] redir_pc;
`ifdef REDIRECT_STATS_EN
  logic [31:0] br_redir_cnt, exc_redir_cnt;
`endif

  ex_redirect_ctl dut (
    .clk(clk), .rst_n(rst_n),
    .br_do_jump(br_do_jump), .br_jump_pc(br_jump_pc),
    .exc_req(exc_req), .exc_vector(exc_vector),
    .redir_ready(redir_ready),
    .flush_out(flush_out), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .ex_hold(ex_hold), .exc_ack(exc_ack)
`ifdef REDIRECT_STATS_EN
    , .br_redir_cnt(br_redir_cnt), .exc_redir_cnt(exc_redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    bit          is_exc;
  } redir_t;

  redir_t      exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          acks_exp = 0;
  int          acks_seen = 0;
  logic [31:0] m_br_cnt = 0;
  logic [31:0] m_exc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [63:0] pc, input bit is_exc);
    redir_t r;
    r.pc = pc;
    r.is_exc = is_exc;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every handshake must match the oldest outstanding redirect.
  always @(negedge clk) begin
    if (rst_n && exc_ack) acks_seen++;
    if (rst_n && redir_valid && redir_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got pc %h, want no transfer", redir_pc);
      end else begin
        redir_t e;
        e = exp_q.pop_front();
        chk("xfer_pc", redir_pc, e.pc);
        if (e.is_exc) m_exc_cnt++;
        else          m_br_cnt++;
      end
    end
  end

  // kind: 0 branch, 1 exception, 2 both same cycle, 3 exc preempts SEND,
  //       4 exc during FLUSH, 5 exc in SEND with ready (chained)
  task automatic run(input int kind, input logic [63:0] a, input logic [63:0] b, input int dly);
    redir_ready = 1'b0;
    chk("idle_hold", ex_hold, 0);
    case (kind)
      1: begin exc_req = 1; exc_vector = a; push(a, 1); acks_exp++; end
      2: begin br_do_jump = 1; br_jump_pc = b; exc_req = 1; exc_vector = a; push(a, 1); acks_exp++; end
      default: begin br_do_jump = 1; br_jump_pc = a; if (kind == 0) push(a, 0); end
    endcase
    tick();
    br_do_jump = 0; exc_req = 0;
    chk("n1_flush", flush_out, 1);
    chk("n1_hold", ex_hold, 1);
    chk("n1_valid", redir_valid, 0);
    chk("n1_ack", exc_ack, (kind == 1 || kind == 2) ? 1 : 0);
    if (kind == 4) begin
      exc_req = 1; exc_vector = b; push(b, 1); acks_exp++;
      tick();
      exc_req = 0;
      chk("flush_rep", flush_out, 1);
      chk("flush_rep_ack", exc_ack, 1);
    end
    tick();
    chk("n2_valid", redir_valid, 1);
    chk("n2_flush", flush_out, 0);
    if (kind == 3) begin
      repeat (dly) begin
        chk("hold_pc", redir_pc, a);
        tick();
      end
      exc_req = 1; exc_vector = b; push(b, 1); acks_exp++;
      tick();
      exc_req = 0;
      chk("preempt_flush", flush_out, 1);
      chk("preempt_valid", redir_valid, 0);
      tick();
    end else if (kind == 5) begin
      push(a, 0);
      redir_ready = 1; exc_req = 1; exc_vector = b; push(b, 1); acks_exp++;
      tick();
      redir_ready = 0; exc_req = 0;
      chk("chain_flush", flush_out, 1);
      chk("chain_valid", redir_valid, 0);
      tick();
    end
    repeat (dly) begin
      chk("wait_valid", redir_valid, 1);
      chk("wait_hold", ex_hold, 1);
      tick();
    end
    redir_ready = 1;
    tick();
    redir_ready = 0;
    chk("post_valid", redir_valid, 0);
    chk("post_hold", ex_hold, 0);
  endtask

  initial begin
    #2;
    chk("rst_valid", redir_valid, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_hold", ex_hold, 0);
    chk("rst_ack", exc_ack, 0);
    chk("rst_pc", redir_pc, 64'h0);
    tick();
    rst_n = 1;
    tick();

    run(0, 64'h1000, 64'h0, 0);
    run(0, 64'h2000, 64'h0, 5);
    run(2, 64'hFFFF_0000, 64'h3000, 1);
    run(3, 64'h4000, 64'h100, 2);
    run(4, 64'h5000, 64'h200, 1);
    run(5, 64'h6000, 64'h300, 0);

    // Reset during SEND discards the pending redirect.
    redir_ready = 0; br_do_jump = 1; br_jump_pc = 64'h7000;
    tick();
    br_do_jump = 0;
    tick();
    chk("pre_rst_valid", redir_valid, 1);
    rst_n = 0;
    exp_q.delete();
    #1;
    chk("arst_valid", redir_valid, 0);
    chk("arst_hold", ex_hold, 0);
    chk("arst_flush", flush_out, 0);
    chk("arst_pc", redir_pc, 64'h0);
    m_br_cnt = 0; m_exc_cnt = 0;
    redir_ready = 1;
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("post_rst_valid", redir_valid, 0);
    redir_ready = 0;

    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 5)), rnd64(), rnd64(), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) begin
        redir_ready = 1'($urandom);
        tick();
      end
      redir_ready = 0;
    end

`ifdef REDIRECT_STATS_EN
    tick();
    chk("br_cnt", br_redir_cnt, m_br_cnt);
    chk("exc_cnt", exc_redir_cnt, m_exc_cnt);
    dut.r_br_cnt = 32'hFFFF_FFFF;
    m_br_cnt = 32'hFFFF_FFFF;
    #1;
    run(0, 64'h8000, 64'h0, 1);
    tick();
    chk("br_cnt_wrap", br_redir_cnt, 32'h0);
    chk("br_cnt_model", br_redir_cnt, m_br_cnt);
    chk("exc_cnt_end", exc_redir_cnt, m_exc_cnt);
`endif

    repeat (2) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    chk("ack_count", 64'(acks_seen), 64'(acks_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
